// File: rtl/dpr_fifo_ctrl_pkg.sv
// Shared definitions for the dual-port-RAM FIFO controller: output-stage
// state encoding and width helpers derived from the RAM address width.
package dpr_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OS_EMPTY = 2'd0,
    OS_ONE   = 2'd1,
    OS_TWO   = 2'd2
  } out_state_e;

  localparam int ADDR_SIZE_DEF = 8;

  function automatic int ram_size(input int addr_size);
    return 1 << addr_size;
  endfunction

  // level counts RAM words plus up to two more in flight / in the output stage
  function automatic int level_w(input int addr_size);
    return addr_size + 2;
  endfunction

endpackage

// File: rtl/dpr_out_stage.sv
// Two-entry head/skid output buffer: absorbs the RAM read latency and
// presents the head word first-word-fall-through.
module dpr_out_stage
  import dpr_fifo_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 arrive,
  input  logic [DATA_SIZE-1:0] arrive_data,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [1:0]           cnt,
  output logic [1:0]           cnt_nxt
);

  out_state_e           state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;
  logic                 pop;

  assign m_valid = (state_q != OS_EMPTY);
  assign m_data  = head_q;
  assign cnt     = state_q;
  assign cnt_nxt = state_d;
  assign pop     = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OS_EMPTY;
    end else begin
      unique case (state_q)
        OS_EMPTY: if (arrive) begin
          head_d  = arrive_data;
          state_d = OS_ONE;
        end
        OS_ONE: begin
          if (arrive && pop) begin
            head_d = arrive_data;
          end else if (arrive) begin
            skid_d  = arrive_data;
            state_d = OS_TWO;
          end else if (pop) begin
            state_d = OS_EMPTY;
          end
        end
        OS_TWO: if (pop) begin
          // skid shifts to head; a same-cycle arrival refills the skid
          head_d = skid_q;
          if (arrive) skid_d = arrive_data;
          else        state_d = OS_ONE;
        end
        default: state_d = OS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OS_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/dpr_fifo_ctrl.sv
// FIFO controller driving a true dual-port RAM: writes on port A, reads on
// port B, with a 2-entry output stage hiding the 1-cycle read latency.
module dpr_fifo_ctrl
  import dpr_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = 8,
  parameter int RAM_SIZE  = ram_size(ADDR_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [ADDR_SIZE+1:0] level,
  output logic                 ram_en_a,
  output logic                 ram_we_a,
  output logic [ADDR_SIZE-1:0] ram_addr_a,
  output logic [DATA_SIZE-1:0] ram_din_a,
  output logic                 ram_en_b,
  output logic                 ram_we_b,
  output logic [ADDR_SIZE-1:0] ram_addr_b,
  input  logic [DATA_SIZE-1:0] ram_dout_b
);

  localparam int LVL_W = level_w(ADDR_SIZE);

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   ram_cnt_q, ram_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [1:0]           out_cnt, out_cnt_nxt;
  logic [2:0]           occ;
  logic                 push, pop, issue;

  assign pop = m_valid & m_ready;
  assign occ = {1'b0, out_cnt} + {2'b00, inflight_q};

  always_comb begin
    s_ready = ~rst & ~flush & (ram_cnt_q < (ADDR_SIZE+1)'(RAM_SIZE));
    push    = s_valid & s_ready;
    // out_cnt + inflight - pop < 2, rearranged to stay unsigned
    issue   = ~rst & ~flush & (ram_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop}));

    wr_ptr_d   = wr_ptr_q + ADDR_SIZE'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(issue);
    ram_cnt_d  = ram_cnt_q + (ADDR_SIZE+1)'(push) - (ADDR_SIZE+1)'(issue);
    inflight_d = issue;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
    end
    level_d = {1'b0, ram_cnt_d} + LVL_W'(inflight_d) + LVL_W'(out_cnt_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  assign level      = level_q;
  assign ram_en_a   = push;
  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr_q;
  assign ram_din_a  = s_data;
  assign ram_en_b   = issue;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr_q;

  // data in flight during a flush cycle is dropped by the output stage
  dpr_out_stage #(.DATA_SIZE(DATA_SIZE)) u_out (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .arrive      (inflight_q),
    .arrive_data (ram_dout_b),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .cnt         (out_cnt),
    .cnt_nxt     (out_cnt_nxt)
  );

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// Bench for dpr_fifo_ctrl with a behavioural RAM and a queue-based model of
// the FIFO (RAM words, word in flight, output words).
module tb_dpr_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int RS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [AW+1:0] level;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_dout_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RAM_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
  );

  // behavioural true dual-port RAM, 1-cycle read latency on port B
  logic [DW-1:0] mem [RS];
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
  end

  // reference model
  logic [DW-1:0] ram_q[$];
  logic [DW-1:0] fl_q[$];
  logic [DW-1:0] out_q[$];
  int            wr_cnt, rd_cnt;
  logic          exp_sr, exp_mv, exp_pop, exp_issue, exp_push;
  logic [DW-1:0] exp_md;
  logic [AW-1:0] exp_addr_a, exp_addr_b;
  int            exp_level;

  task automatic model_clear();
    ram_q.delete(); fl_q.delete(); out_q.delete();
    wr_cnt = 0; rd_cnt = 0;
  endtask

  task automatic model_eval();
    int occ;
    exp_sr     = (ram_q.size() < RS) && !flush;
    exp_push   = s_valid && exp_sr;
    exp_mv     = (out_q.size() != 0);
    exp_md     = exp_mv ? out_q[0] : '0;
    exp_pop    = exp_mv && m_ready;
    occ        = out_q.size() + fl_q.size() - (exp_pop ? 1 : 0);
    exp_issue  = (ram_q.size() != 0) && (occ < 2) && !flush;
    exp_addr_a = AW'(wr_cnt % RS);
    exp_addr_b = AW'(rd_cnt % RS);
    exp_level  = ram_q.size() + fl_q.size() + out_q.size();
  endtask

  task automatic model_tick();
    if (flush) begin
      model_clear();
    end else begin
      if (exp_pop) void'(out_q.pop_front());
      if (fl_q.size() != 0) out_q.push_back(fl_q.pop_front());
      if (exp_issue) begin fl_q.push_back(ram_q.pop_front()); rd_cnt++; end
      if (exp_push) begin ram_q.push_back(s_data); wr_cnt++; end
    end
  endtask

  // drive one cycle's inputs, evaluate the model, land on the sampling edge
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, ram_en_a, ram_we_a, ram_en_b, ram_we_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 000000", {s_ready, m_valid, ram_en_a, ram_we_a, ram_en_b, ram_we_b});
    end
    checks++;
    if (m_data !== 8'h00 || level !== 4'd0) begin
      failures++; $display("FAIL reset_state: m_data=%0h level=%0d want 0/0", m_data, level);
    end
    rst = 1'b0;
    model_clear();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_sready: got %b want 1", s_ready); end
    tick();
  endtask

  task automatic test_latency();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    checks++;
    if ({ram_en_a, ram_we_a} !== 2'b11 || ram_addr_a !== 2'd0 || ram_din_a !== 8'hA1) begin
      failures++; $display("FAIL lat_write: en/we=%b addr=%0d din=%0h want 11/0/a1", {ram_en_a, ram_we_a}, ram_addr_a, ram_din_a);
    end
    tick();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ram_en_b !== 1'b1 || ram_addr_b !== 2'd0 || ram_we_b !== 1'b0) begin
      failures++; $display("FAIL lat_issue: en_b=%b addr_b=%0d we_b=%b want 1/0/0", ram_en_b, ram_addr_b, ram_we_b);
    end
    tick();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL lat_early: m_valid=%b want 0", m_valid); end
    tick();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1 || level !== 4'd1) begin
      failures++; $display("FAIL lat_head: mv=%b md=%0h lvl=%0d want 1/a1/1", m_valid, m_data, level);
    end
    tick();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin
      failures++; $display("FAIL lat_drain: mv=%b lvl=%0d want 0/0", m_valid, level);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [DW-1:0] words [7];
    int acc = 0;
    int k = 0;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0);
      checks++;
      if (s_ready !== exp_sr) begin failures++; $display("FAIL fill_sready[%0d]: got %b want %b", i, s_ready, exp_sr); end
      if (s_ready === 1'b1) acc++;
      tick();
    end
    checks++;
    if (acc != 6) begin failures++; $display("FAIL fill_accepted: got %0d want 6", acc); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (level !== 4'd6) begin failures++; $display("FAIL fill_level: got %0d want 6", level); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (s_ready !== exp_sr || ram_en_b !== exp_issue) begin
        failures++; $display("FAIL drain_ctl[%0d]: sr=%b en_b=%b want %b/%b", c, s_ready, ram_en_b, exp_sr, exp_issue);
      end
      if (c < 6) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== words[k]) begin
          failures++; $display("FAIL drain_word[%0d]: mv=%b md=%0h want 1/%0h", c, m_valid, m_data, words[k]);
        end
        k++;
      end
      tick();
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL drain_empty: mv=%b lvl=%0d", m_valid, level); end
    tick();
  endtask

  task automatic test_stream();
    int idx = 0, got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      step(idx < 16, 8'(idx), 1'b1, 1'b0);
      checks++;
      if (ram_en_a !== exp_push || (exp_push && ram_addr_a !== exp_addr_a) || ram_en_b !== exp_issue
          || (exp_issue && ram_addr_b !== exp_addr_b)) begin
        failures++;
        $display("FAIL stream_ram[%0d]: en_a=%b a=%0d en_b=%b b=%0d want %b/%0d/%b/%0d", c, ram_en_a, ram_addr_a,
                 ram_en_b, ram_addr_b, exp_push, exp_addr_a, exp_issue, exp_addr_b);
      end
      checks++;
      if (level !== exp_level[AW+1:0] || level > 4'd3) begin
        failures++; $display("FAIL stream_level[%0d]: got %0d want %0d (<=3)", c, level, exp_level);
      end
      if (got > 0) begin
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL stream_gap[%0d]: m_valid=%b want 1", c, m_valid); end
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 8'(got)) begin failures++; $display("FAIL stream_data[%0d]: got %0h want %0h", c, m_data, got); end
        got++;
      end
      if (exp_push) idx++;
      tick();
    end
    checks++;
    if (got != 16) begin failures++; $display("FAIL stream_count: got %0d want 16", got); end
  endtask

  task automatic test_backpressure();
    int idx = 0, got = 0;
    logic hold = 1'b0;
    logic [DW-1:0] held = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      step(idx < 5, 8'hB0 + 8'(idx), c[0], 1'b0);
      if (hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          failures++; $display("FAIL bp_stable[%0d]: mv=%b md=%0h want 1/%0h", c, m_valid, m_data, held);
        end
      end
      checks++;
      if (m_valid !== exp_mv || (exp_mv && m_data !== exp_md)) begin
        failures++; $display("FAIL bp_head[%0d]: mv=%b md=%0h want %b/%0h", c, m_valid, m_data, exp_mv, exp_md);
      end
      hold = m_valid && !m_ready;
      held = m_data;
      if (exp_pop) got++;
      if (exp_push) idx++;
      tick();
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (got != 5 || m_valid !== 1'b0) begin failures++; $display("FAIL bp_count: got %0d mv=%b want 5/0", got, m_valid); end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0); tick(); end
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if ({s_ready, ram_en_a, ram_en_b} !== 3'b000) begin
      failures++; $display("FAIL flush_ctl: sr/en_a/en_b=%b want 000", {s_ready, ram_en_a, ram_en_b});
    end
    tick();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL flush_clear: mv=%b lvl=%0d want 0/0", m_valid, level); end
    tick();
    step(1'b1, 8'h9C, 1'b0, 1'b0);
    checks++;
    if (ram_en_a !== 1'b1 || ram_addr_a !== 2'd0) begin
      failures++; $display("FAIL flush_ptr: en_a=%b addr=%0d want 1/0", ram_en_a, ram_addr_a);
    end
    tick();
    for (int i = 0; i < 2; i++) begin step(1'b0, 8'h00, 1'b0, 1'b0); tick(); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h9C || level !== 4'd1) begin
      failures++; $display("FAIL flush_repush: mv=%b md=%0h lvl=%0d want 1/9c/1", m_valid, m_data, level);
    end
    tick();
    step(1'b0, 8'h00, 1'b1, 1'b0); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      checks++;
      if (s_ready !== exp_sr || m_valid !== exp_mv || (exp_mv && m_data !== exp_md) || level !== exp_level[AW+1:0]) begin
        failures++;
        $display("FAIL rand_out[%0d]: sr=%b mv=%b md=%0h lvl=%0d want %b/%b/%0h/%0d", c, s_ready, m_valid, m_data, level,
                 exp_sr, exp_mv, exp_md, exp_level);
      end
      checks++;
      if (ram_en_a !== exp_push || (exp_push && ram_addr_a !== exp_addr_a) || ram_en_b !== exp_issue
          || (exp_issue && ram_addr_b !== exp_addr_b)) begin
        failures++;
        $display("FAIL rand_ram[%0d]: en_a=%b a=%0d en_b=%b b=%0d want %b/%0d/%b/%0d", c, ram_en_a, ram_addr_a,
                 ram_en_b, ram_addr_b, exp_push, exp_addr_a, exp_issue, exp_addr_b);
      end
      tick();
    end
    for (int c = 0; c < 10; c++) begin step(1'b0, 8'h00, 1'b1, 1'b0); tick(); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) begin step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0); tick(); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    // model now holds level 4 with one word in flight
    checks++;
    if (level !== 4'd4 || fl_q.size() != 1) begin failures++; $display("FAIL rst_setup: lvl=%0d want 4", level); end
    s_valid = 1'b1; s_data = 8'h33; m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, ram_en_a, ram_en_b, s_ready} !== 4'b0000 || level !== 4'd0) begin
      failures++; $display("FAIL rst_mid: mv/en_a/en_b/sr=%b lvl=%0d want 0000/0", {m_valid, ram_en_a, ram_en_b, s_ready}, level);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    step(1'b1, 8'h5A, 1'b0, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin step(1'b0, 8'h00, 1'b0, 1'b0); tick(); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A) begin failures++; $display("FAIL rst_repush: mv=%b md=%0h want 1/5a", m_valid, m_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dpr_fifo_ctrl.md
Name: dpr_fifo_ctrl

Overview:
Synchronous FIFO controller that acts as the initiator for the true dual-port RAM. It writes through RAM port A and reads through RAM port B. It accepts words on a valid/ready write interface and presents them first-word-fall-through on a valid/ready read interface. A 2-entry output stage absorbs the RAM's 1-cycle read latency so the read side sustains one word per cycle.

Parameters:
ADDR_SIZE, 8, RAM address width
DATA_SIZE, 8, word width
RAM_SIZE, 1<<ADDR_SIZE, RAM depth (must equal 2**ADDR_SIZE)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all contents
s_valid  input  1  write request
s_ready  output  1  write accept
s_data  input  DATA_SIZE  write word
m_valid  output  1  read data available
m_ready  input  1  read consume
m_data  output  DATA_SIZE  head word
level  output  ADDR_SIZE+2  total words held (RAM + in-flight + output stage)
ram_en_a  output  1  RAM port A enable
ram_we_a  output  1  RAM port A write enable
ram_addr_a  output  ADDR_SIZE  RAM port A address
ram_din_a  output  DATA_SIZE  RAM port A write data
ram_en_b  output  1  RAM port B enable
ram_we_b  output  1  RAM port B write enable, constant 0
ram_addr_b  output  ADDR_SIZE  RAM port B address
ram_dout_b  input  DATA_SIZE  RAM port B read data, valid 1 cycle after ram_en_b

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, out_cnt=0; m_valid=0, m_data=0, level=0, all ram_en/we=0. s_ready is 0 while rst is high and 1 in the first cycle after release.
- Write: push = s_valid & s_ready. s_ready = (ram_cnt < RAM_SIZE) & ~flush. On push, drive ram_en_a=1, ram_we_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data combinationally, in the same cycle. wr_ptr increments mod RAM_SIZE with natural wrap.
- ram_cnt counts words written but not yet issued for read; width ADDR_SIZE+1. Update per cycle: ram_cnt + push - issue.
- Read issue: issue = (ram_cnt != 0) & (out_cnt + inflight - pop < 2) & ~flush. Drive ram_en_b=1, ram_addr_b=rd_ptr. rd_ptr increments mod RAM_SIZE. inflight <= issue, so inflight is 0 or 1.
- Because ram_cnt is registered, a word is issued for read no earlier than the cycle after its write. The same address is never written and read in one cycle, so RAM collision mode is irrelevant.
- Output stage FSM (out_cnt): EMPTY(0), ONE(1), TWO(2). Entry 0 is the head and drives m_data; entry 1 is the skid.
- m_valid = (out_cnt != 0). pop = m_valid & m_ready.
- When inflight=1, ram_dout_b is loaded into the first free slot after the pop shift. Transitions:
  - EMPTY + arrival -> ONE.
  - ONE + arrival without pop -> TWO.
  - ONE + arrival with pop -> ONE (head replaced).
  - ONE + pop only -> EMPTY.
  - TWO + pop -> ONE (skid moves to head); an arrival on the same cycle gives TWO.
  - TWO + arrival without pop cannot occur, because the issue rule prevents it.
- Latency: first push at cycle t gives m_valid=1 at t+3 (write t, issue t+1, data t+2 captured at edge end of t+2).
- Throughput: continuous push with m_ready=1 gives one pop per cycle after the initial fill.
- level = ram_cnt + inflight + out_cnt, registered together with the counters. Maximum value is RAM_SIZE+2.
- flush (synchronous): next cycle all pointers and counters are 0 and m_valid=0. s_ready, issue, and RAM enables are 0 during the flush cycle. Any in-flight RAM data is discarded. Flush takes priority over push and pop.
- rst asserted mid-operation: immediate clear as in reset; RAM contents are don't-care.
- m_data holds its value while m_valid & ~m_ready (stable under backpressure).

Decomposition:
- Shared package: the output-stage state encoding (EMPTY/ONE/TWO), plus constants for RAM_SIZE and the level width derived from ADDR_SIZE.
- One natural sub-module, dpr_out_stage: the 2-entry skid/head buffer with its valid/ready logic, taking arrival and arrival data.
- Pointer and count logic stays in the top module.

Test Plan:
- ADDR_SIZE=2, DATA_SIZE=8. Push A1 at t=0 with m_ready=0 -> ram_we_a=1, ram_addr_a=0 at t=0; ram_en_b=1, ram_addr_b=0 at t=1; m_valid=1, m_data=A1 from t=3; level=1.
- Push 11,22,33,44,55,66 back-to-back with m_ready=0 -> six accepted, s_ready=0 on the seventh attempt, level=6; then m_ready=1 -> 11..66 pop in order, one per cycle, and s_ready returns 1 after the first issue.
- Continuous push 00..0F with m_ready=1 -> output 00..0F with no gaps after the first m_valid; wr_ptr/rd_ptr wrap 3->0 four times; level never exceeds 3.
- Alternate m_ready 1/0 during streaming of 5 words -> no loss or duplication, m_data stable on every m_ready=0 cycle.
- Fill with 3 words, assert flush for 1 cycle together with s_valid -> push rejected, next cycle m_valid=0 and level=0; a subsequent push of 9C appears as the head after 3 cycles.
- Assert rst while level=4 and inflight=1 -> m_valid=0, level=0, ram_en_a/b=0 immediately; after release, push 5A -> m_data=5A.
